fetch_unit: RTL and testbench

Instruction fetch sequencer for the single-issue MIPS core. Holds the PC, requests instruction words from instruction memory over a request/valid handshake, and presents each fetched word (with its 6-bit opcode field) to the control decoder and datapath. It consumes the decoder's `jmp`/`branch` outputs and the datapath's branch-condition result to compute the next PC. Sits between instruction memory and the control decoder/register file.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/next_pc_calc.sv | 27 ++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: opcode encodings, fetch FSM states
// and the default reset PC.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_ISSUE,
        ST_HALT
    } fetch_state_e;

    function automatic logic is_legal_opcode(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection for the fetch unit: jump target, taken-branch target or
// sequential PC, with jump taking priority over branch.
module next_pc_calc (
    input  logic [31:0] pc_plus4,
    input  logic [25:0] target,
    input  logic        jmp,
    input  logic        branch,
    input  logic        branch_taken,
    output logic [31:0] next_pc
);

    logic [31:0] branch_offset;

    // Low 16 bits of the jump field are the branch immediate.
    assign branch_offset = {{14{target[15]}}, target[15:0], 2'b00};

    always_comb begin
        if (jmp) begin
            next_pc = {pc_plus4[31:28], target, 2'b00};
        end else if (branch && branch_taken) begin
            next_pc = pc_plus4 + branch_offset;
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: holds the PC, fetches over a req/valid
// handshake and issues words to the decoder. Optional feature: FETCH_ILLEGAL_OP_EN.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        issue_ack,
    input  logic        jmp,
    input  logic        branch,
    input  logic        branch_taken,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        illegal
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         req_q, req_d;
    logic         instr_valid_q, instr_valid_d;
    logic         illegal_q, illegal_d;
    logic         illegal_hit;
    logic         capture;
    logic [31:0]  next_pc;

`ifdef FETCH_ILLEGAL_OP_EN
    assign illegal_hit = !is_legal_opcode(imem_rdata[31:26]);
`else
    assign illegal_hit = 1'b0;
`endif

    // Responses are only accepted while waiting; strobes in other states are dropped.
    assign capture = (state_q == ST_WAIT) && imem_valid;

    next_pc_calc u_next_pc_calc (
        .pc_plus4     (pc_plus4),
        .target       (instr_q[25:0]),
        .jmp          (jmp),
        .branch       (branch),
        .branch_taken (branch_taken),
        .next_pc      (next_pc)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            req_q         <= 1'b0;
            instr_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            req_q         <= req_d;
            instr_valid_q <= instr_valid_d;
            illegal_q     <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (imem_valid) begin
                    state_d = illegal_hit ? ST_HALT : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_ack) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        illegal_d     = illegal_q;
        req_d         = (state_d == ST_FETCH) || (state_d == ST_WAIT);
        instr_valid_d = (state_d == ST_ISSUE);
        if (capture) begin
            instr_d = imem_rdata;
            if (illegal_hit) begin
                illegal_d = 1'b1;
            end
        end
        if ((state_q == ST_ISSUE) && issue_ack) begin
            pc_d = next_pc;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, memory latency, branch,
// jump, PC wrap, back-pressure, reset mid-fetch and the illegal-opcode option.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        issue_ack;
    logic        jmp;
    logic        branch;
    logic        branch_taken;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        illegal;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] W_ADDI   = 32'h2008_0005;
    localparam logic [31:0] W_J_200  = 32'h0800_0080;
    localparam logic [31:0] W_BEQ_M2 = 32'h1000_FFFE;
    localparam logic [31:0] W_J_TOP  = 32'h0BFF_FFFF;
    localparam logic [31:0] W_J_10   = 32'h0800_0004;
    localparam logic [31:0] W_J_100  = 32'h0800_0040;
    localparam logic [31:0] W_BEQ_P3 = 32'h1000_0003;
    localparam logic [31:0] W_BAD    = 32'hFC00_0000;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_valid   (imem_valid),
        .instr        (instr),
        .opcode       (opcode),
        .instr_valid  (instr_valid),
        .issue_ack    (issue_ack),
        .jmp          (jmp),
        .branch       (branch),
        .branch_taken (branch_taken),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in WAIT: optional response delay, issue, optional ack hold-off, ack.
    task automatic wait_issue(input string tag, input logic [31:0] addr, input logic [31:0] word,
                              input int delay, input int hold,
                              input logic j, input logic b, input logic t);
        for (int i = 0; i < delay; i++) begin
            check({tag, ":req_held"}, 32'(imem_req), 32'd1);
            check({tag, ":no_valid_in_wait"}, 32'(instr_valid), 32'd0);
            tick();
        end
        imem_valid = 1'b1;
        imem_rdata = word;
        tick();
        imem_valid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check({tag, ":instr_valid"}, 32'(instr_valid), 32'd1);
        check({tag, ":instr"}, instr, word);
        check({tag, ":pc"}, pc, addr);
        check({tag, ":pc_plus4"}, pc_plus4, addr + 32'd4);
        check({tag, ":req_low_in_issue"}, 32'(imem_req), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, ":hold_valid"}, 32'(instr_valid), 32'd1);
            check({tag, ":hold_instr"}, instr, word);
            check({tag, ":hold_pc"}, pc, addr);
        end
        jmp          = j;
        branch       = b;
        branch_taken = t;
        issue_ack    = 1'b1;
        tick();
        jmp          = 1'b0;
        branch       = 1'b0;
        branch_taken = 1'b0;
        issue_ack    = 1'b0;
        check({tag, ":valid_falls"}, 32'(instr_valid), 32'd0);
    endtask

    // Starts in FETCH.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] word,
                         input int delay, input int hold,
                         input logic j, input logic b, input logic t);
        check({tag, ":fetch_req"}, 32'(imem_req), 32'd1);
        check({tag, ":fetch_addr"}, imem_addr, addr);
        tick();
        check({tag, ":wait_req"}, 32'(imem_req), 32'd1);
        wait_issue(tag, addr, word, delay, hold, j, b, t);
    endtask

    initial begin
        logic [31:0] base;
        rst          = 1'b1;
        imem_rdata   = '0;
        imem_valid   = 1'b0;
        issue_ack    = 1'b0;
        jmp          = 1'b0;
        branch       = 1'b0;
        branch_taken = 1'b0;

        tick();
        tick();
        check("rst:req", 32'(imem_req), 32'd0);
        check("rst:instr_valid", 32'(instr_valid), 32'd0);
        check("rst:instr", instr, 32'd0);
        check("rst:addr", imem_addr, 32'h0000_0100);
        check("rst:illegal", 32'(illegal), 32'd0);

        rst = 1'b0;
        tick();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0000_0100);
        wait_issue("addi", 32'h0000_0100, W_ADDI, 0, 0, 1'b0, 1'b0, 1'b0);
        check("addi:opcode_after", 32'(opcode), 32'd8);

        fetch("latency_jmp", 32'h0000_0104, W_J_200, 5, 0, 1'b1, 1'b0, 1'b0);
        fetch("beq_taken", 32'h0000_0200, W_BEQ_M2, 0, 0, 1'b0, 1'b1, 1'b1);
        fetch("jmp_back", 32'h0000_01FC, W_J_200, 1, 0, 1'b1, 1'b0, 1'b0);
        fetch("beq_not_taken", 32'h0000_0200, W_BEQ_M2, 0, 0, 1'b0, 1'b1, 1'b0);
        fetch("jmp_top0", 32'h0000_0204, W_J_TOP, 0, 0, 1'b1, 1'b0, 1'b0);
        fetch("seq_top0", 32'h0FFF_FFFC, W_ADDI, 0, 0, 1'b0, 1'b0, 1'b0);

        // Climb through every 256 MB region, ending with the 0xFFFFFFFC wrap.
        for (int n = 1; n < 16; n++) begin
            base = 32'(n) << 28;
            if (n == 3) begin
                fetch("jmp_3_10", base, W_J_10, 0, 0, 1'b1, 1'b0, 1'b0);
                fetch("jmp_prio", 32'h3000_0010, W_J_100, 0, 0, 1'b1, 1'b1, 1'b1);
                fetch("jmp_3_top", 32'h3000_0100, W_J_TOP, 0, 0, 1'b1, 1'b0, 1'b0);
            end else begin
                fetch("jmp_region", base, W_J_TOP, 0, 0, 1'b1, 1'b0, 1'b0);
            end
            fetch("seq_region", base | 32'h0FFF_FFFC, W_ADDI, 0, 0, 1'b0, 1'b0, 1'b0);
        end

        fetch("backpressure", 32'h0000_0000, W_BEQ_P3, 0, 4, 1'b0, 1'b1, 1'b1);

        // Reset while waiting for memory; the late strobe must be dropped.
        check("midrst:fetch_addr", imem_addr, 32'h0000_0010);
        tick();
        tick();
        check("midrst:waiting", 32'(imem_req), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst:req_cleared", 32'(imem_req), 32'd0);
        check("midrst:addr", imem_addr, 32'h0000_0100);
        check("midrst:instr_cleared", instr, 32'd0);
        rst        = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = W_ADDI;
        tick();
        imem_valid = 1'b0;
        check("late_valid:instr_valid", 32'(instr_valid), 32'd0);
        check("late_valid:instr", instr, 32'd0);
        check("late_valid:req", 32'(imem_req), 32'd1);
        check("late_valid:addr", imem_addr, 32'h0000_0100);
        tick();
        check("late_valid:still_waiting", 32'(instr_valid), 32'd0);

`ifdef FETCH_ILLEGAL_OP_EN
        imem_valid = 1'b1;
        imem_rdata = W_BAD;
        tick();
        imem_valid = 1'b0;
        check("illegal:flag", 32'(illegal), 32'd1);
        check("illegal:no_issue", 32'(instr_valid), 32'd0);
        check("illegal:no_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt:no_req", 32'(imem_req), 32'd0);
            check("halt:no_issue", 32'(instr_valid), 32'd0);
            check("halt:sticky", 32'(illegal), 32'd1);
        end
`else
        wait_issue("bad_op_issued", 32'h0000_0100, W_BAD, 0, 0, 1'b0, 1'b0, 1'b0);
        check("bad_op:illegal_tied", 32'(illegal), 32'd0);
        check("bad_op:next_req", 32'(imem_req), 32'd1);
        check("bad_op:next_addr", imem_addr, 32'h0000_0104);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
